// File: rtl/mbm_pkg.sv
// Shared types and constants for the Mitchell-multiplier sequencer.
// MBM_BIAS_C is only consumed when MBM_BIAS_COMP_EN is defined.
package mbm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOD_A = 3'd1,
    LOD_B = 3'd2,
    CALC  = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int          FRAC_W     = 7;
  localparam int          PROD_W     = 16;
  localparam logic [6:0]  MBM_BIAS_C = 7'd5;

endpackage

// File: rtl/lod.sv
// Leading-one detector: position of the most significant set bit of an 8-bit word.
// An all-zero input reports position 0; callers never present zero.
module lod (
  input  logic [7:0] i_data,
  output logic [2:0] o_pos
);

  always_comb begin
    o_pos = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (i_data[i]) o_pos = 3'(i);
    end
  end

endmodule

// File: rtl/mbm_seq_ctrl.sv
// Sequenced Mitchell log multiplier sharing one lod between both operands.
// Define MBM_BIAS_COMP_EN to add a saturating bias to the summed fraction.
//
// Handshake: a beat transfers on a rising edge where valid && ready are both
// high; the source holds data/valid until then, and the sink may stall freely.
module mbm_seq_ctrl
  import mbm_pkg::*;
#(
  parameter int W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [W-1:0]      in_a,
  input  logic [W-1:0]      in_b,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [PROD_W-1:0] out_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       op_count,
  output logic [2:0]        o_dbg_state
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [W-1:0]        r_a;
  logic [W-1:0]        r_b;
  logic [2:0]          r_ka;
  logic [2:0]          r_kb;
  logic [PROD_W-1:0]   r_out_p;
  logic [15:0]         r_op_count;

  logic                w_zero_op;
  logic [W-1:0]        w_lod_in;
  logic [2:0]          w_lod_pos;
  logic [FRAC_W-1:0]   w_xa;
  logic [FRAC_W-1:0]   w_xb;
  logic [FRAC_W:0]     w_s;
  logic [FRAC_W-1:0]   w_f;
  logic [3:0]          w_e;
  logic [PROD_W-1:0]   w_mant;
  logic [PROD_W-1:0]   w_prod;

  assign w_zero_op = (in_a == '0) || (in_b == '0);
  assign w_lod_in  = (r_state == LOD_B) ? r_b : r_a;

  lod u_lod (
    .i_data (w_lod_in),
    .o_pos  (w_lod_pos)
  );

  // Normalised fractions: shift the leading one out above bit 6.
  assign w_xa = FRAC_W'(r_a << (3'd7 - r_ka));
  assign w_xb = FRAC_W'(r_b << (3'd7 - r_kb));
  assign w_s  = {1'b0, w_xa} + {1'b0, w_xb};
  assign w_e  = {1'b0, r_ka} + {1'b0, r_kb} + {3'b000, w_s[FRAC_W]};

`ifdef MBM_BIAS_COMP_EN
  logic [FRAC_W:0] w_f_biased;
  assign w_f_biased = {1'b0, w_s[FRAC_W-1:0]} + {1'b0, MBM_BIAS_C};
  assign w_f        = w_f_biased[FRAC_W] ? 7'h7F : w_f_biased[FRAC_W-1:0];
`else
  assign w_f = w_s[FRAC_W-1:0];
`endif

  // ({1,f} << e) >> 7 without building the wide intermediate.
  assign w_mant = {8'h00, 1'b1, w_f};
  assign w_prod = (w_e >= 4'd7) ? (w_mant << (w_e - 4'd7))
                                : (w_mant >> (4'd7 - w_e));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_zero_op ? DONE : LOD_A;
      LOD_A:   w_state_nxt = LOD_B;
      LOD_B:   w_state_nxt = CALC;
      CALC:    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_ka       <= '0;
      r_kb       <= '0;
      r_out_p    <= '0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_out_p <= '0;
          end
        end
        LOD_A: r_ka    <= w_lod_pos;
        LOD_B: r_kb    <= w_lod_pos;
        CALC:  r_out_p <= w_prod;
        DONE:  if (out_ready) r_op_count <= r_op_count + 16'd1;
        default: ;
      endcase
    end
  end

  assign in_ready    = (r_state == IDLE);
  assign out_valid   = (r_state == DONE);
  assign out_p       = r_out_p;
  assign op_count    = r_op_count;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mbm_seq_ctrl.sv
// Directed scoreboard bench for mbm_seq_ctrl; expected products follow the
// MBM_BIAS_COMP_EN build setting.
module tb_mbm_seq_ctrl;
  import mbm_pkg::*;

  logic        clk;
  logic        rst;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_p;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] op_count;
  logic [2:0]  dbg_state;

  int          n_checks;
  int          n_fail;
  int          n_done;
  logic [15:0] exp_q[$];

  mbm_seq_ctrl #(.W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_p       (out_p),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .op_count    (op_count),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, act=timeout req=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: act=%0d req=%0d at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: act=%0d req=none", out_p);
      end else begin
        check("sb_out_p", 32'(out_p), 32'(exp_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && (dbg_state == LOD_A || dbg_state == LOD_B)) begin
      if (dut.w_lod_in == 8'd0) begin
        n_checks++;
        n_fail++;
        $display("FAIL lod_in_zero: act=0 req=nonzero state=%0d", dbg_state);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (!in_ready && guard < 50) begin
      step();
      guard++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
  endtask

  // Issues one operand pair, pushes the expectation, checks latency and count.
  task automatic issue_op(input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp_p, input int exp_lat);
    int lat;
    wait_ready();
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    exp_q.push_back(exp_p);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    if (out_ready) begin
      step();
      n_done++;
      check("op_count", 32'(op_count), 32'(n_done));
      check("in_ready_after", 32'(in_ready), 32'd1);
    end
  endtask

  // ---------------- expected values ----------------
`ifdef MBM_BIAS_COMP_EN
  localparam logic [15:0] EXP_8_8     = 16'd66;
  localparam logic [15:0] EXP_255_255 = 16'd65280;
  localparam logic [15:0] EXP_128_2   = 16'd266;
`else
  localparam logic [15:0] EXP_8_8     = 16'd64;
  localparam logic [15:0] EXP_255_255 = 16'd65024;
  localparam logic [15:0] EXP_128_2   = 16'd256;
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    n_done    = 0;
    rst       = 1'b1;
    in_a      = '0;
    in_b      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p",     32'(out_p),     32'd0);
    check("rst_op_count",  32'(op_count),  32'd0);

    // Abandon an operation with reset while in LOD_B.
    in_a     = 8'd3;
    in_b     = 8'd5;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("abort_in_lod_b", 32'(dbg_state), 32'(LOD_B));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_op_count",  32'(op_count),  32'd0);
    check("abort_in_ready",  32'(in_ready),  32'd1);
    repeat (6) begin
      step();
      check("abort_no_result", 32'(out_valid), 32'd0);
    end

    issue_op(8'd2,   8'd2,   16'd4,       4);
    issue_op(8'd3,   8'd5,   16'd14,      4);
    issue_op(8'd8,   8'd8,   EXP_8_8,     4);
    issue_op(8'd255, 8'd255, EXP_255_255, 4);
    issue_op(8'd0,   8'd200, 16'd0,       1);
    issue_op(8'd7,   8'd0,   16'd0,       1);
    issue_op(8'd1,   8'd1,   16'd1,       4);
    issue_op(8'd128, 8'd2,   EXP_128_2,   4);

    // Backpressure: hold the result for 10 cycles, then a one-cycle pulse.
    out_ready = 1'b0;
    issue_op(8'd8, 8'd8, EXP_8_8, 4);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_p",     32'(out_p),     32'(EXP_8_8));
      check("bp_in_ready",  32'(in_ready),  32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_done++;
    check("bp_release_in_ready", 32'(in_ready),  32'd1);
    check("bp_release_valid",    32'(out_valid), 32'd0);
    check("bp_op_count",         32'(op_count),  32'(n_done));
    out_ready = 1'b1;

    repeat (3) step();
    check("sb_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mbm_seq_ctrl.md
MBM_SEQ_CTRL -- requirements
Module: mbm_seq_ctrl

Interface
REQ-001 SHALL have parameter W, default 8, meaning operand width; only W=8 is supported, matching the 8-bit lod.
REQ-002 SHALL have port clk, input, 1 bit: single rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have ports in_a and in_b, input, 8 bits each: unsigned operands.
REQ-005 SHALL have port in_valid, input, 1 bit, and port in_ready, output, 1 bit: operand handshake.
REQ-006 SHALL have port out_p, output, 16 bits: approximate unsigned product.
REQ-007 SHALL have port out_valid, output, 1 bit, and port out_ready, input, 1 bit: result handshake.
REQ-008 SHALL have port op_count, output, 16 bits: number of completed results.

Function
REQ-009 SHALL use one shared lod instance, time-multiplexed between the operands.
- lod_in = b_q in state LOD_B, else a_q.
REQ-010 SHALL use FSM states IDLE, LOD_A, LOD_B, CALC and DONE.
REQ-011 SHALL drive in_ready = (state==IDLE).
- A transfer occurs when in_valid && in_ready; a_q and b_q are registered on that edge.
REQ-012 SHALL, on a transfer with a nonzero and b nonzero, sequence IDLE->LOD_A->LOD_B->CALC->DONE.
- ka is captured in LOD_A; kb is captured in LOD_B.
REQ-013 SHALL, on a transfer with either operand zero, go IDLE->DONE with product 0.
- The lod is never consulted for a zero operand.
REQ-014 SHALL compute fractions xa = (a_q << (7-ka))[6:0] and xb likewise, each 7 fraction bits.
REQ-015 SHALL compute, in CALC: s = xa + xb (8 bits), f = s[6:0], e = ka + kb + s[7].
- out_p = ({1,f} << e) >> 7, truncated, registered.
REQ-016 SHALL assert out_valid only in DONE.
- out_p SHALL be held stable while out_valid && !out_ready.
REQ-017 SHALL, in DONE with out_ready=1, return to IDLE and increment op_count.
- op_count wraps 0xFFFF->0x0000.
REQ-018 SHALL NOT accept a new operand in the same cycle a result is consumed.
- Throughput is 1 op per 5 cycles nonzero, 2 cycles zero, with out_ready held high.
REQ-019 SHALL raise out_valid in the 4th cycle after the transfer edge for nonzero operands and in the 1st cycle for zero operands.

Reset
REQ-020 SHALL, on rst=1 at a clock edge, set state=IDLE, out_valid=0, out_p=0, op_count=0, a_q=b_q=0, ka=kb=0.
- rst takes priority over all other inputs.
REQ-021 SHALL treat reset during any non-IDLE state as abandoning the operation.
- No result is produced and op_count is not incremented.
- in_ready=1 in the first cycle after reset is released.

Configuration
REQ-022 SHALL, when macro MBM_BIAS_COMP_EN is defined, use f = min(s[6:0] + MBM_BIAS_C, 7'h7F) in CALC.
- The addition saturates, with no carry into e.
REQ-023 SHALL, when MBM_BIAS_COMP_EN is undefined, implement plain Mitchell with f = s[6:0].
- Ports and latency are identical in both builds.

Structure
REQ-024 SHALL take the following from shared package mbm_pkg:
- state enum type
- MBM_BIAS_C = 7'd5
- frac width 7
- product width 16
REQ-025 SHALL instantiate existing sub-module lod (8-bit in, 3-bit position out) exactly once.
- lod has no other sub-modules.

Verification
REQ-026 SHALL check a=3, b=5, out_ready=1:
- out_valid in the 4th cycle after transfer; out_p=14 in both builds.
- op_count=1 after consumption.
REQ-027 SHALL check a=8, b=8:
- out_p=64 without MBM_BIAS_COMP_EN; out_p=66 with it.
REQ-028 SHALL check a=255, b=255:
- out_p=65024 without the macro; out_p=65280 with it (saturated f).
REQ-029 SHALL check a=0, b=200:
- out_valid in the 1st cycle after transfer, out_p=0.
- Assert lod_in never equals 0 while the FSM is in LOD_A or LOD_B.
REQ-030 SHALL check backpressure: out_ready=0 for 10 cycles in DONE.
- out_p and out_valid are stable and in_ready=0 throughout.
- A pulse of out_ready then gives in_ready=1 on the next cycle.
REQ-031 SHALL check reset: assert rst in LOD_B, then deassert.
- out_valid=0, op_count unchanged at 0, in_ready=1 on the first post-reset cycle.
- A new a=2, b=2 yields out_p=4.
